// File: rtl/pulse_measure_if.sv
// Bundle of the pulse measurement signals: pulse input, control and results.
// The master drives stimulus and control; the slave is the measuring block.
interface pulse_measure_if #(
  parameter int CNT_W = 16
);
  logic             pulse_in;
  logic             clear;
  logic [1:0]       sel;
  logic [CNT_W-1:0] width;
  logic [CNT_W-1:0] period;
  logic             valid;
  logic             overflow;
  logic [7:0]       led;

  modport master (
    output pulse_in, clear, sel,
    input  width, period, valid, overflow, led
  );

  modport slave (
    input  pulse_in, clear, sel,
    output width, period, valid, overflow, led
  );
endinterface

// File: rtl/pulse_measure.sv
// Measures high time and rise-to-rise period of an asynchronous pulse stream
// after synchronisation, with saturation detection and a byte-wide display mux.
module pulse_measure #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic            CLOCK_50,
  input logic            reset_n,
  pulse_measure_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t                 state_reg, state_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic                   sync, rise, fall;
  logic [CNT_W-1:0]       hw_reg, hw_next;
  logic [CNT_W-1:0]       per_reg, per_next;
  logic [CNT_W-1:0]       width_reg, width_next;
  logic [CNT_W-1:0]       period_reg, period_next;
  logic                   valid_reg, valid_next;
  logic                   overflow_reg, overflow_next;
  logic                   sat_hit;
  logic [7:0]             led_reg, led_next;
  logic [15:0]            width16, period16;

  assign sync = sync_reg[SYNC_STAGES-1];
  assign rise = sync & ~prev_reg;
  assign fall = ~sync & prev_reg;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.pulse_in};
      prev_reg <= sync;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      hw_reg       <= '0;
      per_reg      <= '0;
      width_reg    <= '0;
      period_reg   <= '0;
      valid_reg    <= 1'b0;
      overflow_reg <= 1'b0;
      led_reg      <= 8'h00;
    end else begin
      state_reg    <= state_next;
      hw_reg       <= hw_next;
      per_reg      <= per_next;
      width_reg    <= width_next;
      period_reg   <= period_next;
      valid_reg    <= valid_next;
      overflow_reg <= overflow_next;
      led_reg      <= led_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    hw_next       = hw_reg;
    per_next      = per_reg;
    width_next    = width_reg;
    period_next   = period_reg;
    valid_next    = 1'b0;
    overflow_next = overflow_reg;
    sat_hit       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (rise) begin
          hw_next    = CNT_ONE;
          per_next   = CNT_ONE;
          state_next = HIGH;
        end
      end
      HIGH: begin
        // hw_cnt never exceeds per_cnt, but both are tested while high
        if (sync) begin
          if ((per_reg == CNT_MAX) || (hw_reg == CNT_MAX)) begin
            sat_hit = 1'b1;
          end else begin
            hw_next  = hw_reg + CNT_ONE;
            per_next = per_reg + CNT_ONE;
          end
        end else if (fall) begin
          if (per_reg == CNT_MAX) begin
            sat_hit = 1'b1;
          end else begin
            per_next   = per_reg + CNT_ONE;
            state_next = LOW;
          end
        end
      end
      LOW: begin
        if (rise) begin
          width_next  = hw_reg;
          period_next = per_reg;
          valid_next  = 1'b1;
          hw_next     = CNT_ONE;
          per_next    = CNT_ONE;
          state_next  = HIGH;
        end else if (per_reg == CNT_MAX) begin
          sat_hit = 1'b1;
        end else begin
          per_next = per_reg + CNT_ONE;
        end
      end
      default: state_next = IDLE;
    endcase

    // A saturated measurement is abandoned; results keep their last values
    if (sat_hit) begin
      overflow_next = 1'b1;
      state_next    = IDLE;
    end

    if (bus.clear) begin
      state_next    = IDLE;
      hw_next       = '0;
      per_next      = '0;
      width_next    = '0;
      period_next   = '0;
      valid_next    = 1'b0;
      overflow_next = 1'b0;
    end
  end

  // Display view is always 16 bits; bits above CNT_W read as zero
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_disp
      if (gi < CNT_W) begin : g_bit
        assign width16[gi]  = width_reg[gi];
        assign period16[gi] = period_reg[gi];
      end else begin : g_pad
        assign width16[gi]  = 1'b0;
        assign period16[gi] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    led_next = 8'h00;
    case (bus.sel)
      2'b00:   led_next = width16[7:0];
      2'b01:   led_next = width16[15:8];
      2'b10:   led_next = period16[7:0];
      default: led_next = period16[15:8];
    endcase
  end

  assign bus.width    = width_reg;
  assign bus.period   = period_reg;
  assign bus.valid    = valid_reg;
  assign bus.overflow = overflow_reg;
  assign bus.led      = led_reg;

endmodule

// File: tb/tb_pulse_measure.sv
// Randomised and directed bench for pulse_measure; expectations come from a
// pulse-level model working on the edge times of the driven stream.
module tb_pulse_measure;

  localparam int CNT_W = 16;
  localparam int SYNC  = 2;
  localparam int MAX   = (1 << CNT_W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pulse_measure_if #(.CNT_W(CNT_W)) bus ();

  pulse_measure #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC)
  ) dut (
    .CLOCK_50(clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    int due;
    int w;
    int p;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb[$];

  // pulse-level model state, indexed by drive cycle
  bit armed   = 1'b0;
  bit prev_v  = 1'b0;
  bit ovf_exp = 1'b0;
  int last_rise = 0;
  int last_fall = 0;
  int ovf_cyc   = -10;
  int cur_w     = 0;
  int cur_p     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int exp_led(input int s);
    case (s)
      0:       return cur_w & 255;
      1:       return (cur_w >> 8) & 255;
      2:       return cur_p & 255;
      default: return (cur_p >> 8) & 255;
    endcase
  endfunction

  task automatic model_reset();
    sb.delete();
    armed   = 1'b0;
    ovf_exp = 1'b0;
    ovf_cyc = -10;
    cur_w   = 0;
    cur_p   = 0;
  endtask

  task automatic monitor();
    if (cyc == ovf_cyc - 1) check("ovf_early", 32'(bus.overflow), 0);
    if (cyc == ovf_cyc)     check("ovf_set", 32'(bus.overflow), 1);
    if (sb.size() > 0 && sb[0].due == cyc) begin
      check("valid", 32'(bus.valid), 1);
      check("width", 32'(bus.width), sb[0].w);
      check("period", 32'(bus.period), sb[0].p);
      $display("cycle %0d: measurement width=%0d period=%0d", cyc, sb[0].w, sb[0].p);
      cur_w = sb[0].w;
      cur_p = sb[0].p;
      void'(sb.pop_front());
    end else if (bus.valid !== 1'b0) begin
      check("valid_spurious", 32'(bus.valid), 0);
    end
  endtask

  // One clock of stimulus: update the model, drive, advance, observe
  task automatic step(input bit v, input bit clr);
    exp_t e;
    if (clr) model_reset();
    if (v && !prev_v) begin
      if (armed && (cyc - last_rise) <= MAX) begin
        e.due = cyc + SYNC + 1;
        e.w   = last_fall - last_rise;
        e.p   = cyc - last_rise;
        sb.push_back(e);
      end
      armed     = 1'b1;
      last_rise = cyc;
    end else if (armed && (cyc - last_rise) == MAX) begin
      armed = 1'b0;
      if (!ovf_exp) ovf_cyc = cyc + SYNC + 1;
      ovf_exp = 1'b1;
    end
    if (!v && prev_v) last_fall = cyc;
    prev_v       = v;
    bus.pulse_in = v;
    bus.clear    = clr;
    @(negedge clk);
    cyc++;
    monitor();
  endtask

  task automatic pulse(input int hi, input int lo);
    repeat (hi) step(1'b1, 1'b0);
    repeat (lo) step(1'b0, 1'b0);
  endtask

  task automatic checkpoint(input string tag);
    for (int s = 0; s < 4; s++) begin
      bus.sel = 2'(s);
      step(prev_v, 1'b0);
      step(prev_v, 1'b0);
      check($sformatf("%s_led%0d", tag, s), 32'(bus.led), exp_led(s));
    end
    check({tag, "_width"}, 32'(bus.width), cur_w);
    check({tag, "_period"}, 32'(bus.period), cur_p);
    check({tag, "_ovf"}, 32'(bus.overflow), 32'(ovf_exp));
  endtask

  initial begin
    bus.pulse_in = 1'b0;
    bus.clear    = 1'b0;
    bus.sel      = 2'b00;

    repeat (3) @(negedge clk);
    check("rst_width", 32'(bus.width), 0);
    check("rst_period", 32'(bus.period), 0);
    check("rst_valid", 32'(bus.valid), 0);
    check("rst_ovf", 32'(bus.overflow), 0);
    check("rst_led", 32'(bus.led), 0);
    rst_n = 1'b1;

    // three 3-high/5-low periods
    repeat (3) pulse(3, 5);
    checkpoint("p3_5");

    for (int i = 0; i < 30; i++) begin
      pulse(int'($urandom_range(1, 12)), int'($urandom_range(2, 12)));
      if (i % 10 == 9) checkpoint("rand");
    end

    pulse(300, 700);
    pulse(4, 4);
    checkpoint("p300_700");

    // long low time forces per_cnt saturation
    pulse(3, 70000);
    checkpoint("sat");
    pulse(4, 6);
    pulse(4, 6);
    checkpoint("post_sat");

    // clear coincident with a LOW-state rise
    pulse(5, 5);
    repeat (SYNC) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("clr_width", 32'(bus.width), 0);
    check("clr_period", 32'(bus.period), 0);
    check("clr_ovf", 32'(bus.overflow), 0);
    repeat (3) step(1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0);
    pulse(3, 5);
    pulse(3, 5);
    checkpoint("post_clr");

    // reset in the middle of a high phase
    bus.sel = 2'b00;
    pulse(3, 5);
    repeat (SYNC + 2) step(1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("arst_width", 32'(bus.width), 0);
    check("arst_period", 32'(bus.period), 0);
    check("arst_valid", 32'(bus.valid), 0);
    check("arst_ovf", 32'(bus.overflow), 0);
    check("arst_led", 32'(bus.led), 0);
    model_reset();
    prev_v = 1'b0;
    repeat (3) begin
      @(negedge clk);
      cyc++;
    end
    rst_n = 1'b1;
    repeat (3) step(1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0);
    pulse(3, 5);
    checkpoint("post_rst");

    repeat (10) step(1'b0, 1'b0);
    check("pending", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_measure.md
PULSE_MEASURE -- requirements
Module: pulse_measure

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16: width in bits of the width and period counters and their result registers.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2: number of flip-flops in the pulse_in synchroniser (minimum 2).
REQ-003 Port CLOCK_50, input, width 1: the single clock; all state changes on its rising edge.
REQ-004 Port reset_n, input, width 1: reset, asynchronous assert, active-low.
REQ-005 Port pulse_in, input, width 1: asynchronous pulse stream, produced by the upstream pulse generator.
REQ-006 Port clear, input, width 1: synchronous, active-high; discards the measurement in progress and clears the results.
REQ-007 Port sel, input, width 2: selects the byte shown on led.
REQ-008 Port width, output, width CNT_W: last completed high time, in clock cycles.
REQ-009 Port period, output, width CNT_W: last completed rise-to-rise time, in clock cycles.
REQ-010 Port valid, output, width 1: one-cycle strobe when width and period update.
REQ-011 Port overflow, output, width 1: sticky flag; a counter reached saturation.
REQ-012 Port led, output, width 8: registered display byte.

Function
REQ-013 pulse_in SHALL pass through SYNC_STAGES flops to give sync, then one more flop to give prev.
REQ-014 rise = sync & ~prev; fall = ~sync & prev.
REQ-015 All measured counts SHALL be in terms of sync. A synchronous input held high N cycles and low M cycles SHALL measure width=N and period=N+M.
REQ-016 The FSM SHALL have three states: IDLE, HIGH and LOW.
REQ-017 IDLE: on rise, load hw_cnt=1 and per_cnt=1, then go to HIGH. Otherwise hold.
REQ-018 HIGH, sync=1: hw_cnt+1 and per_cnt+1.
REQ-019 HIGH, fall: per_cnt+1 and hw_cnt hold, then go to LOW.
REQ-020 LOW, no rise: per_cnt+1.
REQ-021 LOW, on rise: load width=hw_cnt and period=per_cnt, assert valid for exactly that cycle (registered), load hw_cnt=1 and per_cnt=1, and go to HIGH.
REQ-022 valid SHALL assert on the clock edge after the rise cycle; width and period SHALL be stable from that edge onward.
REQ-023 Saturation: when an increment would take per_cnt past 2^CNT_W-1, the block SHALL set overflow, go to IDLE, leave width and period unchanged, and not assert valid. The same rule applies to hw_cnt.
REQ-024 The first rise after reset, after clear or after saturation SHALL only start a measurement; it SHALL produce no valid.
REQ-025 clear=1 SHALL force IDLE, width=0, period=0, valid=0, overflow=0 and both counters to 0. clear SHALL win over a simultaneous rise or saturation.
REQ-026 overflow SHALL stay set until clear or reset.
REQ-027 led SHALL be registered with one cycle of latency from sel, width or period:
- sel=00: width[7:0]
- sel=01: width[15:8]
- sel=10: period[7:0]
- sel=11: period[15:8]
REQ-028 If CNT_W<16, the missing upper bits on led SHALL read 0.
REQ-029 A pulse shorter than one clock that sync does not capture SHALL be ignored, with no error flag.

Reset
REQ-030 While reset_n=0, the block SHALL hold: state=IDLE; width, period, hw_cnt and per_cnt=0; valid=0; overflow=0; led=0; and all synchroniser and prev flops at 0.
REQ-031 On reset_n deassertion, the first rising edge SHALL begin normal operation.
REQ-032 An input already high at deassertion SHALL be seen as a rise SYNC_STAGES+1 cycles later, and SHALL only start a measurement.
REQ-033 Reset mid-measurement SHALL discard the partial counts.

Verification
REQ-034 The bench SHALL drive pulse_in high 3 and low 5 for three periods -> valid twice, each time width=3 and period=8; led=03 with sel=00 and led=08 with sel=10.
REQ-035 The bench SHALL hold pulse_in at 0 for 70000 cycles after one rise, with CNT_W=16 -> overflow=1 at per_cnt=65535, no valid, and the next two rises give valid again while overflow stays 1.
REQ-036 The bench SHALL assert clear on the same cycle as a LOW-state rise -> no valid, width=0, period=0 and state=IDLE. The following rise produces no valid; the one after that does.
REQ-037 The bench SHALL assert reset_n=0 mid-HIGH after width=3 and period=8 are latched -> all outputs 0 asynchronously, and the first post-reset rise produces no valid.
REQ-038 The bench SHALL drive pulse_in high 300 and low 700 -> width=300 (0x012C) and period=1000 (0x03E8); led=01 with sel=01 and led=03 with sel=11.
